lfsr_seq_ctrl: RTL
==================

Name: lfsr_seq_ctrl

Overview:
Command-driven controller that owns a 4-bit Fibonacci LFSR (feedback = q[3]^q[2], shift toward MSB, feedback into bit 0).
- Accepts seed-load, step-N, free-run and stop commands over a valid/ready interface.
- Paces shifts with an internal tick divider in place of a derived slow clock.
- Reports each new value, a done pulse, and period detection (return to the loaded value).
- Sits between a host/test sequencer and any consumer of the pseudo-random stream.

Parameters:
CNT_W, 8, width of the step-count operand and of period_len
DIV, 1, clk cycles per LFSR shift (>=1); 1 = shift every cycle

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted when cmd_valid&&cmd_ready
cmd_op  input  2  00 LOAD, 01 STEP, 10 FREE, 11 STOP
cmd_seed  input  4  seed for LOAD
cmd_count  input  CNT_W  number of shifts for STEP
lfsr_q  output  4  current LFSR register
q_valid  output  1  one-cycle pulse: lfsr_q holds a freshly shifted value
busy  output  1  high in RUN
done  output  1  one-cycle pulse at end of STEP or on STOP
period_hit  output  1  pulse with q_valid when lfsr_q equals loaded reference
period_len  output  CNT_W  shifts from LOAD to first period_hit (0 until found)
zero_err  output  1  sticky: zero seed loaded or run attempted on zero state

Behaviour:
- Reset: lfsr_q=0000, state IDLE, busy=0, q_valid=0, done=0, period_hit=0, period_len=0, zero_err=0, ref=0000, divider=0, remaining=0.
- cmd_ready = (state==IDLE) || (cmd_op==STOP).
- LOAD, nonzero seed:
  - Seed is loaded bit-reversed: lfsr_q[0]=seed[3], [1]=seed[2], [2]=seed[1], [3]=seed[0]; ref takes the same value.
  - Clears zero_err, period_len and the step-since-load counter.
  - Stays IDLE; lfsr_q updates on the accept edge; no q_valid.
- LOAD, seed 0000: lfsr_q and ref unchanged; zero_err set.
- STEP, count>0, lfsr_q!=0: go to RUN, remaining=count, divider cleared.
- FREE, lfsr_q!=0: go to RUN with no count limit.
- STEP with count=0: done pulses in the cycle after accept, no shift, stays IDLE.
- STEP/FREE with lfsr_q==0: done pulses the next cycle, zero_err set, no shift.
- RUN timing:
  - Divider counts 0..DIV-1; a shift occurs on the edge where divider==DIV-1, then divider wraps to 0.
  - First shift is DIV cycles after the accept edge.
  - The shift is q <= {q[2:0], q[3]^q[2]}.
  - q_valid is high for the one cycle following each shift, coincident with the new lfsr_q.
- Period detection:
  - The step-since-load counter increments per shift and saturates at all-ones.
  - On the first shift where the new q==ref, period_hit pulses and period_len latches the count; later hits pulse period_hit but do not relatch period_len.
- STEP termination: remaining decrements per shift; the final shift's q_valid cycle also carries done=1; return to IDLE the same edge (busy low next cycle).
- STOP:
  - In RUN: accepted immediately; no further shifts; done pulses next cycle; return to IDLE; lfsr_q holds.
  - If a shift coincides with the STOP accept edge, that shift still completes.
  - In IDLE: accepted, no effect, no done.
- Reset mid-RUN: everything returns to reset values on that edge; no done.
- Non-STOP commands in RUN are not accepted (cmd_ready low).

Decomposition:
- Shared package lfsr_pkg:
  - opcodes OP_LOAD/OP_STEP/OP_FREE/OP_STOP
  - state encoding IDLE/RUN
  - tap constants TAP_HI=3, TAP_LO=2
- One sub-module lfsr4_core (load, load data, shift enable, q), instantiated once.
- Controller FSM, divider and counters stay in lfsr_seq_ctrl.

Test Plan:
- LOAD seed 1000 -> lfsr_q=0001 next cycle, no q_valid; STEP 3 (DIV=1) -> q_valid on 3 consecutive cycles with 0010, 0100, 1001; done with 1001; busy then low.
- LOAD 1000, FREE, run 15 shifts -> 15th q_valid shows 0001 with period_hit=1, period_len=15; the sequence visits all 15 nonzero values; STOP -> done next cycle, lfsr_q holds.
- LOAD 0000 after reset -> zero_err=1, lfsr_q=0000; STEP 5 -> done next cycle, no q_valid; LOAD 0001 -> zero_err clears, lfsr_q=1000.
- DIV=4, LOAD 1000, STEP 2 -> q_valid spaced exactly 4 cycles apart (0010 then 0100), first one 4 cycles after accept.
- STEP 10, assert rst after 3rd shift -> lfsr_q=0000, busy=0, no done; STEP 0 in IDLE -> done only, lfsr_q unchanged.
- In RUN, present LOAD -> cmd_ready=0 and state unaffected; present STOP on a shift edge -> that shift's q_valid occurs, then done, no further shifts.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 4-bit LFSR sequencer: command opcodes, controller
// states, feedback taps and the next-value / seed-reversal helpers.
package lfsr_pkg;

   typedef enum logic [1:0] {
      OP_LOAD = 2'b00,
      OP_STEP = 2'b01,
      OP_FREE = 2'b10,
      OP_STOP = 2'b11
   } op_e;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam int TAP_HI = 3;
   localparam int TAP_LO = 2;

   function automatic logic [3:0] lfsr_next(input logic [3:0] q);
      return {q[2:0], q[TAP_HI] ^ q[TAP_LO]};
   endfunction

   // Seeds arrive MSB-first on the bus but land LSB-first in the register.
   function automatic logic [3:0] bit_rev4(input logic [3:0] s);
      return {s[0], s[1], s[2], s[3]};
   endfunction

endpackage

// File: rtl/lfsr4_core.sv
// 4-bit Fibonacci LFSR register with parallel load and shift enable.
module lfsr4_core
   import lfsr_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [3:0] load_data,
   input  logic       shift,
   output logic [3:0] q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= 4'b0000;
      end else if (load) begin
         q <= load_data;
      end else if (shift) begin
         q <= lfsr_next(q);
      end
   end

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Command-driven sequencer around lfsr4_core: seed load, counted or free-running
// shifts paced by a tick divider, and period detection against the loaded seed.
//
// state | meaning
// IDLE  | waiting for a command; LOAD/STEP/FREE/STOP accepted
// RUN   | shifting once per DIV cycles; only STOP accepted
module lfsr_seq_ctrl
   import lfsr_pkg::*;
#(
   parameter int CNT_W = 8,
   parameter int DIV   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [3:0]       cmd_seed,
   input  logic [CNT_W-1:0] cmd_count,
   output logic [3:0]       lfsr_q,
   output logic             q_valid,
   output logic             busy,
   output logic             done,
   output logic             period_hit,
   output logic [CNT_W-1:0] period_len,
   output logic             zero_err
);

   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(DIV - 1);

   state_e           state, state_nxt;
   op_e              op;
   logic             accept, shift_en, load_en, run_start, done_nxt, zero_set;
   logic             free_mode, found;
   logic [DIV_W-1:0] div_cnt;
   logic [CNT_W-1:0] remaining, step_cnt, step_inc;
   logic [3:0]       seed_rev, q_next, ref_q;

   assign op        = op_e'(cmd_op);
   assign cmd_ready = (state == IDLE) || (op == OP_STOP);
   assign accept    = cmd_valid && cmd_ready;
   assign busy      = (state == RUN);
   assign shift_en  = (state == RUN) && (div_cnt == DIV_TC);
   assign seed_rev  = bit_rev4(cmd_seed);
   assign q_next    = lfsr_next(lfsr_q);
   assign step_inc  = (step_cnt == '1) ? step_cnt : step_cnt + 1'b1;

   lfsr4_core u_core (
      .clk       (clk),
      .rst       (rst),
      .load      (load_en),
      .load_data (seed_rev),
      .shift     (shift_en),
      .q         (lfsr_q)
   );

   always_comb begin
      state_nxt = state;
      load_en   = 1'b0;
      run_start = 1'b0;
      done_nxt  = 1'b0;
      zero_set  = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               case (op)
                  OP_LOAD: begin
                     if (cmd_seed != 4'b0000) load_en  = 1'b1;
                     else                     zero_set = 1'b1;
                  end
                  OP_STEP: begin
                     if (cmd_count == '0) begin
                        done_nxt = 1'b1;
                     end else if (lfsr_q == 4'b0000) begin
                        done_nxt = 1'b1;
                        zero_set = 1'b1;
                     end else begin
                        state_nxt = RUN;
                        run_start = 1'b1;
                     end
                  end
                  OP_FREE: begin
                     if (lfsr_q == 4'b0000) begin
                        done_nxt = 1'b1;
                        zero_set = 1'b1;
                     end else begin
                        state_nxt = RUN;
                        run_start = 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
         end
         RUN: begin
            // accept in RUN can only be STOP; a coincident shift still lands
            if (accept || (shift_en && !free_mode && remaining == CNT_W'(1))) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         q_valid    <= 1'b0;
         done       <= 1'b0;
         period_hit <= 1'b0;
         period_len <= '0;
         zero_err   <= 1'b0;
         ref_q      <= 4'b0000;
         div_cnt    <= '0;
         remaining  <= '0;
         step_cnt   <= '0;
         found      <= 1'b0;
         free_mode  <= 1'b0;
      end else begin
         state      <= state_nxt;
         q_valid    <= shift_en;
         done       <= done_nxt;
         period_hit <= shift_en && (q_next == ref_q);
         if (zero_set) zero_err <= 1'b1;
         if (load_en) begin
            ref_q      <= seed_rev;
            zero_err   <= 1'b0;
            period_len <= '0;
            step_cnt   <= '0;
            found      <= 1'b0;
         end
         if (run_start) begin
            div_cnt   <= '0;
            remaining <= cmd_count;
            free_mode <= (op == OP_FREE);
         end else if (state == RUN) begin
            div_cnt <= shift_en ? '0 : div_cnt + 1'b1;
         end
         if (shift_en) begin
            remaining <= remaining - 1'b1;
            step_cnt  <= step_inc;
            if (!found && q_next == ref_q) begin
               found      <= 1'b1;
               period_len <= step_inc;
            end
         end
      end
   end

endmodule
